sa_skew_feeder: RTL and testbench
=================================

Name: sa_skew_feeder

Overview:
- Diagonal-skew front end for the float16 systolic array, generalised to independent ROWS x COLS and any data width.
- Accepts one unskewed k-slice per beat:
  - a column of A, one element per array row;
  - a row of B, one element per array column.
- Emits per-lane delayed streams with per-lane valids, in the staircase pattern the array consumes (0001, 0011, 0111, 1111, 1110, 1100, 1000).
- Adds a stall handshake, tile framing (LAST to TILE_DONE), beat counting and overflow detection.

Parameters:
- ROWS, 4, number of A lanes (array rows).
- COLS, 4, number of B lanes (array columns).
- DW, 16, element width in bits (float16 bit pattern; never interpreted).
- KMAX, 64, maximum beats per tile before overflow is flagged.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous reset, active-high.
- VI  in  1  input beat valid.
- LAST_I  in  1  marks the final beat of a tile; qualified by VI.
- A_I  in  ROWS x DW  A column slice; lane i = A[i][k].
- B_I  in  COLS x DW  B row slice; lane j = B[k][j].
- STALL  in  1  downstream hold request.
- RDY  out  1  beat accepted when VI && RDY.
- DVO_A  out  ROWS  per-lane valid, A side.
- DO_A  out  ROWS x DW  skewed A data.
- DVO_B  out  COLS  per-lane valid, B side.
- DO_B  out  COLS x DW  skewed B data.
- TILE_DONE  out  1  one-cycle pulse when the tile's last element leaves the longest lane.
- BUSY  out  1  any valid or LAST in flight.
- BEAT_CNT  out  $clog2(KMAX+1)  beats accepted in the current tile.
- OVF  out  1  sticky tile-length overflow.

Behaviour:
- Reset: every output register, delay stage and counter goes to 0; OVF=0; RDY follows STALL combinationally. Beats in flight at reset are discarded, and no TILE_DONE is produced for them.
- Handshake: RDY = ~STALL. While STALL=1:
  - all delay stages, outputs and counters hold;
  - VI, A_I, B_I and LAST_I are ignored.
- Skew:
  - beat accepted at edge t → lane i data and valid appear on DO_A[i]/DVO_A[i] at the edge t+1+i (stall cycles excluded from the count);
  - lane 0 latency is 1 cycle; lane ROWS-1 is ROWS cycles; B lanes identical with COLS.
- Bubbles: a non-accepted, non-stalled cycle injects valid=0 and data=0 into stage 0 of every lane. Output data with valid=0 is always 0.
- Back-to-back: consecutive accepted beats produce contiguous valids per lane. A new tile may start the cycle after LAST_I with no gap, and the tiles' skews interleave correctly.
- LAST path:
  - L = max(ROWS, COLS);
  - the accepted LAST_I travels a 1-bit delay of L stages under the same stall rule;
  - TILE_DONE is high for exactly one cycle, coincident with the last valid on the longest lane.
- BEAT_CNT:
  - increments on each accepted beat and saturates at KMAX;
  - the edge that accepts LAST_I loads 0;
  - VI with LAST_I=1 as the first beat is a one-beat tile.
- OVF:
  - set when a beat is accepted with BEAT_CNT==KMAX and LAST_I=0;
  - sticky; cleared only by RST;
  - data flow is unaffected.
- BUSY = OR of all delay-stage valids and LAST stages. It is 0 after the final TILE_DONE cycle completes.
- Simultaneous STALL and VI: the beat is not accepted, and the source must hold it.
- STALL asserted mid-skew: the staircase freezes and resumes intact when STALL drops. No lane advances independently.

Test Plan:
- ROWS=COLS=4. Drive 4 contiguous beats: A_I lanes = {1A11,1A12,1A13,1A14}, {1A21..}, {1A31..}, {1A41..}, LAST on beat 4.
  - Required: DVO_A sequence 0001,0011,0111,1111,1110,1100,1000,0000.
  - DO_A[3] shows 1A14,1A24,1A34,1A44 on cycles 4-7.
  - TILE_DONE pulses at cycle 7.
  - B side is identical.
- STALL held for 3 cycles at cycle 3 of the above → all outputs frozen for those 3 cycles, then the remaining staircase is unchanged and delayed by exactly 3 cycles; RDY=0 throughout the stall.
- Two 4-beat tiles back-to-back → 8 contiguous valids on lane 0 and two TILE_DONE pulses 4 cycles apart.
- ROWS=2, COLS=5, one-beat tile with VI and LAST_I set together:
  - DVO_A valid at cycles 1-2 (lane 0, then lane 1);
  - DVO_B valid at cycles 1-5;
  - TILE_DONE at cycle 5.
- KMAX=4: 5 beats without LAST → BEAT_CNT saturates at 4 and OVF rises on the 5th accept; a later LAST resets BEAT_CNT to 0 while OVF stays 1.
- RST asserted mid-skew, asynchronous between edges → all DVO, data, BUSY and BEAT_CNT go to 0 immediately, and no TILE_DONE occurs after release.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// Diagonal-skew front end for a systolic array: lane i of each side is delayed by i+1 beats,
// with a LAST pipe matching the longest lane, stall hold, beat counting and sticky overflow.
module sa_skew_feeder #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 16,
    parameter int KMAX = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      VI,
    input  logic                      LAST_I,
    input  logic [ROWS-1:0][DW-1:0]   A_I,
    input  logic [COLS-1:0][DW-1:0]   B_I,
    input  logic                      STALL,
    output logic                      RDY,
    output logic [ROWS-1:0]           DVO_A,
    output logic [ROWS-1:0][DW-1:0]   DO_A,
    output logic [COLS-1:0]           DVO_B,
    output logic [COLS-1:0][DW-1:0]   DO_B,
    output logic                      TILE_DONE,
    output logic                      BUSY,
    output logic [$clog2(KMAX+1)-1:0] BEAT_CNT,
    output logic                      OVF
);

    localparam int CW = $clog2(KMAX + 1);
    localparam int L  = (ROWS > COLS) ? ROWS : COLS;
    localparam logic [CW-1:0] KMAX_C = CW'(KMAX);

    logic            adv;
    logic            acc;
    logic [ROWS-1:0] busy_a;
    logic [COLS-1:0] busy_b;
    logic [L-1:0]    last_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    assign adv = ~STALL;
    assign acc = VI & adv;
    assign RDY = adv;

    // A lane i is an (i+1)-stage shift register; bubbles shift in zero data
    for (genvar i = 0; i < ROWS; i++) begin : g_lane_a
        logic [i:0]         v_q;
        logic [i:0][DW-1:0] d_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                v_q <= '0;
                d_q <= '0;
            end else if (adv) begin
                v_q[0] <= acc;
                d_q[0] <= acc ? A_I[i] : '0;
                for (int s = 1; s <= i; s++) begin
                    v_q[s] <= v_q[s-1];
                    d_q[s] <= d_q[s-1];
                end
            end
        end

        assign DVO_A[i]  = v_q[i];
        assign DO_A[i]   = d_q[i];
        assign busy_a[i] = |v_q;
    end

    for (genvar j = 0; j < COLS; j++) begin : g_lane_b
        logic [j:0]         v_q;
        logic [j:0][DW-1:0] d_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                v_q <= '0;
                d_q <= '0;
            end else if (adv) begin
                v_q[0] <= acc;
                d_q[0] <= acc ? B_I[j] : '0;
                for (int s = 1; s <= j; s++) begin
                    v_q[s] <= v_q[s-1];
                    d_q[s] <= d_q[s-1];
                end
            end
        end

        assign DVO_B[j]  = v_q[j];
        assign DO_B[j]   = d_q[j];
        assign busy_b[j] = |v_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= '0;
        end else if (adv) begin
            last_q[0] <= acc & LAST_I;
            for (int s = 1; s < L; s++) begin
                last_q[s] <= last_q[s-1];
            end
        end
    end

    // The done pulse marks the cycle the final element actually leaves, so it is masked while held
    assign TILE_DONE = last_q[L-1] & adv;
    assign BUSY      = (|busy_a) | (|busy_b) | (|last_q);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (acc) begin
            if (LAST_I) begin
                cnt_d = '0;
            end else if (cnt_q == KMAX_C) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign BEAT_CNT = cnt_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: 4x4 staircase, stall, back-to-back tiles,
// a 2x5 one-beat tile, KMAX=4 overflow and asynchronous reset mid-skew.
module tb_sa_skew_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 4x4, KMAX=64
    logic             p44_rst, p44_vi, p44_last, p44_stall;
    logic [3:0][15:0] p44_a, p44_b, p44_doa, p44_dob;
    logic             p44_rdy, p44_td, p44_busy, p44_ovf;
    logic [3:0]       p44_dva, p44_dvb;
    logic [6:0]       p44_cnt;

    // 2x5, KMAX=64
    logic             p25_rst, p25_vi, p25_last, p25_stall;
    logic [1:0][15:0] p25_a, p25_doa;
    logic [4:0][15:0] p25_b, p25_dob;
    logic             p25_rdy, p25_td, p25_busy, p25_ovf;
    logic [1:0]       p25_dva;
    logic [4:0]       p25_dvb;
    logic [6:0]       p25_cnt;

    // 4x4, KMAX=4
    logic             pk4_rst, pk4_vi, pk4_last, pk4_stall;
    logic [3:0][15:0] pk4_a, pk4_b, pk4_doa, pk4_dob;
    logic             pk4_rdy, pk4_td, pk4_busy, pk4_ovf;
    logic [3:0]       pk4_dva, pk4_dvb;
    logic [2:0]       pk4_cnt;

    sa_skew_feeder #(.ROWS(4), .COLS(4), .DW(16), .KMAX(64)) u_dut44 (
        .CLK(clk), .RST(p44_rst), .VI(p44_vi), .LAST_I(p44_last),
        .A_I(p44_a), .B_I(p44_b), .STALL(p44_stall), .RDY(p44_rdy),
        .DVO_A(p44_dva), .DO_A(p44_doa), .DVO_B(p44_dvb), .DO_B(p44_dob),
        .TILE_DONE(p44_td), .BUSY(p44_busy), .BEAT_CNT(p44_cnt), .OVF(p44_ovf)
    );

    sa_skew_feeder #(.ROWS(2), .COLS(5), .DW(16), .KMAX(64)) u_dut25 (
        .CLK(clk), .RST(p25_rst), .VI(p25_vi), .LAST_I(p25_last),
        .A_I(p25_a), .B_I(p25_b), .STALL(p25_stall), .RDY(p25_rdy),
        .DVO_A(p25_dva), .DO_A(p25_doa), .DVO_B(p25_dvb), .DO_B(p25_dob),
        .TILE_DONE(p25_td), .BUSY(p25_busy), .BEAT_CNT(p25_cnt), .OVF(p25_ovf)
    );

    sa_skew_feeder #(.ROWS(4), .COLS(4), .DW(16), .KMAX(4)) u_dutk4 (
        .CLK(clk), .RST(pk4_rst), .VI(pk4_vi), .LAST_I(pk4_last),
        .A_I(pk4_a), .B_I(pk4_b), .STALL(pk4_stall), .RDY(pk4_rdy),
        .DVO_A(pk4_dva), .DO_A(pk4_doa), .DVO_B(pk4_dvb), .DO_B(pk4_dob),
        .TILE_DONE(pk4_td), .BUSY(pk4_busy), .BEAT_CNT(pk4_cnt), .OVF(pk4_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat k lane i: tile 1 uses 1A11..1A44, tile 2 uses 1B11..1B44
    function automatic logic [15:0] av(input int k, input int i);
        return 16'h1A11 + 16'(k % 4) * 16'h0010 + 16'(k / 4) * 16'h0100 + 16'(i);
    endfunction

    function automatic logic [15:0] bv(input int k, input int j);
        return 16'h2B11 + 16'(k % 4) * 16'h0010 + 16'(k / 4) * 16'h0100 + 16'(j);
    endfunction

    // Drives nb contiguous beats (LAST every 4th) into the 4x4 unit with STALL over cycles
    // [s0, s0+sl). e counts un-stalled edges, so the expected picture at e is the stall-free one.
    task automatic run44(input int nb, input int s0, input int sl, input int ncyc, input bit tab);
        logic [3:0]       dv_tab [9];
        logic [15:0]      d3_tab [9];
        logic [3:0]       edva, edvb;
        logic [3:0][15:0] edoa, edob;
        logic             st, etd, ebusy;
        int               b, e, k, m;
        dv_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
        d3_tab = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h1A14,
                   16'h1A24, 16'h1A34, 16'h1A44, 16'h0};
        b = 0;
        e = 0;
        for (int c = 0; c < ncyc; c++) begin
            st        = (c >= s0) && (c < s0 + sl);
            p44_stall = st;
            p44_vi    = (b < nb);
            p44_last  = (b < nb) && (b % 4 == 3);
            for (int i = 0; i < 4; i++) begin
                p44_a[i] = (b < nb) ? av(b, i) : 16'h0;
                p44_b[i] = (b < nb) ? bv(b, i) : 16'h0;
            end
            #1;
            if (c > 0) begin
                edva  = '0;
                edvb  = '0;
                edoa  = '0;
                edob  = '0;
                ebusy = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    k = e - 1 - i;
                    if (k >= 0 && k < nb) begin
                        edva[i] = 1'b1;
                        edvb[i] = 1'b1;
                        edoa[i] = av(k, i);
                        edob[i] = bv(k, i);
                    end
                end
                for (int kk = 0; kk < nb; kk++)
                    if (e - 1 - kk >= 0 && e - 1 - kk <= 3) ebusy = 1'b1;
                k   = e - 4;
                etd = (k >= 0) && (k < nb) && (k % 4 == 3) && !st;
                m   = (e < nb) ? e : nb;
                chk($sformatf("dva c%0d", c), p44_dva, edva);
                chk($sformatf("dvb c%0d", c), p44_dvb, edvb);
                chk($sformatf("doa c%0d", c), p44_doa, edoa);
                chk($sformatf("dob c%0d", c), p44_dob, edob);
                chk($sformatf("tdone c%0d", c), p44_td, etd);
                chk($sformatf("busy c%0d", c), p44_busy, ebusy);
                chk($sformatf("cnt c%0d", c), p44_cnt, 7'(m % 4));
                chk($sformatf("rdy c%0d", c), p44_rdy, !st);
                if (tab && e <= 8) begin
                    chk($sformatf("dva_tab c%0d", c), p44_dva, dv_tab[e]);
                    chk($sformatf("do3_tab c%0d", c), p44_doa[3], d3_tab[e]);
                end
            end
            @(posedge clk);
            if (p44_vi && !st) b++;
            if (!st) e++;
            #1;
        end
        p44_vi    = 1'b0;
        p44_last  = 1'b0;
        p44_stall = 1'b0;
    endtask

    initial begin
        logic [1:0] dva25_tab [8];
        logic [2:0] cnt_tab [5];

        p44_rst = 1'b1; p44_vi = 1'b0; p44_last = 1'b0; p44_stall = 1'b0; p44_a = '0; p44_b = '0;
        p25_rst = 1'b1; p25_vi = 1'b0; p25_last = 1'b0; p25_stall = 1'b0; p25_a = '0; p25_b = '0;
        pk4_rst = 1'b1; pk4_vi = 1'b0; pk4_last = 1'b0; pk4_stall = 1'b0; pk4_a = '0; pk4_b = '0;
        #12;
        chk("rst dva", p44_dva, 4'h0);
        chk("rst doa", p44_doa, 64'h0);
        chk("rst busy", p44_busy, 1'b0);
        chk("rst cnt", p44_cnt, 7'd0);
        chk("rst ovf", p44_ovf, 1'b0);
        chk("rst tdone", p44_td, 1'b0);
        chk("rst rdy", p44_rdy, 1'b1);
        p44_stall = 1'b1;
        #1;
        chk("rst rdy stall", p44_rdy, 1'b0);
        p44_stall = 1'b0;
        @(negedge clk);
        p44_rst = 1'b0;
        p25_rst = 1'b0;
        pk4_rst = 1'b0;
        @(posedge clk);
        #1;

        run44(4, 99, 0, 10, 1'b1);   // plain staircase
        run44(4, 3, 3, 13, 1'b1);    // 3-cycle stall from cycle 3
        run44(8, 99, 0, 14, 1'b0);   // two tiles back-to-back

        // 2x5 one-beat tile
        dva25_tab = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        p25_vi   = 1'b1;
        p25_last = 1'b1;
        p25_a    = {16'hA001, 16'hA000};
        p25_b    = {16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};
        for (int c = 1; c < 8; c++) begin
            @(posedge clk);
            #1;
            p25_vi   = 1'b0;
            p25_last = 1'b0;
            p25_a    = '0;
            p25_b    = '0;
            #1;
            chk($sformatf("p25 dva c%0d", c), p25_dva, dva25_tab[c]);
            chk($sformatf("p25 dvb c%0d", c), p25_dvb, (c <= 5) ? (5'b00001 << (c - 1)) : 5'b0);
            chk($sformatf("p25 tdone c%0d", c), p25_td, c == 5);
            chk($sformatf("p25 busy c%0d", c), p25_busy, c <= 5);
            chk($sformatf("p25 cnt c%0d", c), p25_cnt, 7'd0);
            if (c == 2) chk("p25 doa1 c2", p25_doa[1], 16'hA001);
            if (c == 5) chk("p25 dob4 c5", p25_dob[4], 16'hB004);
        end

        // KMAX=4: five beats without LAST, then LAST
        cnt_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int k = 0; k < 5; k++) begin
            pk4_vi   = 1'b1;
            pk4_last = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pk4_a[i] = av(k, i);
                pk4_b[i] = bv(k, i);
            end
            @(posedge clk);
            #1;
            chk($sformatf("k4 cnt b%0d", k), pk4_cnt, cnt_tab[k]);
            chk($sformatf("k4 ovf b%0d", k), pk4_ovf, k == 4);
        end
        pk4_last = 1'b1;
        @(posedge clk);
        #1;
        pk4_vi   = 1'b0;
        pk4_last = 1'b0;
        chk("k4 cnt last", pk4_cnt, 3'd0);
        chk("k4 ovf last", pk4_ovf, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("k4 ovf sticky", pk4_ovf, 1'b1);
        chk("k4 busy idle", pk4_busy, 1'b0);

        // Asynchronous reset in the middle of a skew
        for (int k = 0; k < 3; k++) begin
            p44_vi   = 1'b1;
            p44_last = 1'b0;
            for (int i = 0; i < 4; i++) begin
                p44_a[i] = av(k, i);
                p44_b[i] = bv(k, i);
            end
            @(posedge clk);
            #1;
        end
        p44_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p44_a[i] = av(3, i);
            p44_b[i] = bv(3, i);
        end
        chk("mid busy", p44_busy, 1'b1);
        chk("mid dva", p44_dva, 4'b0111);
        #2;
        p44_rst = 1'b1;
        #1;
        chk("arst dva", p44_dva, 4'h0);
        chk("arst dvb", p44_dvb, 4'h0);
        chk("arst doa", p44_doa, 64'h0);
        chk("arst dob", p44_dob, 64'h0);
        chk("arst busy", p44_busy, 1'b0);
        chk("arst cnt", p44_cnt, 7'd0);
        p44_vi   = 1'b0;
        p44_last = 1'b0;
        @(negedge clk);
        p44_rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst tdone c%0d", c), p44_td, 1'b0);
            chk($sformatf("post-rst busy c%0d", c), p44_busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
